if_prefetch: RTL
================

# if_prefetch

Parametrised instruction-fetch front end that replaces the single-address fetch stage with a decoupled, buffered fetcher. It owns the fetch PC, issues one read per cycle to the synchronous instruction memory, and queues returned instructions with their PCs in a DEPTH-entry FIFO. Decode consumes entries through a valid/ready handshake. Branch redirect flushes the queue and kills any in-flight read, and halt freezes issue. It sits between the instruction memory and decode.

## Interface
- DATA_W, 16, instruction width
- ADDR_W, 16, PC / instruction address width
- DEPTH, 4, queue entries (legal ≥2; full throughput needs ≥3)
- RESET_PC, 0, fetch address after reset
- PC_INC, 1, PC increment per instruction (word addressing)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- hlt  in  1  level; suppresses new fetch issue
- br_ctrl  in  1  redirect strobe
- new_pc  in  ADDR_W  redirect target, sampled when br_ctrl=1
- imem_rd_en  out  1  read request this cycle
- imem_addr  out  ADDR_W  read address; equals the current fetch PC
- imem_instr  in  DATA_W  read data, valid exactly one cycle after the request
- instr  out  DATA_W  head instruction
- pc  out  ADDR_W  PC of the head instruction
- instr_vld  out  1  head entry valid
- instr_rdy  in  1  decode accepts the head entry
- fetch_pc  out  ADDR_W  next address to fetch (debug)

## Operation
- State:
  - fetch PC
  - inflight bit plus the PC of the in-flight read
  - FIFO of {pc, instr}
  - count
- **Issue condition:** `!rst, !br_ctrl, !hlt, count + inflight < DEPTH`. Uses registered state only; no lookahead on instr_rdy. On issue:
  - imem_rd_en=1, imem_addr=fetch PC
  - fetch PC += PC_INC, modulo 2^ADDR_W (wraps silently)
  - inflight is set for the next cycle
- **Return:** in the cycle after an issue, if inflight is still set, {inflight PC, imem_instr} is pushed at the end of that cycle.
- **Pop:** occurs when instr_vld && instr_rdy. Push and pop in the same cycle leave count unchanged.
- **Redirect (br_ctrl=1):** highest priority.
  - fetch PC <= new_pc
  - FIFO cleared, count <= 0, inflight <= 0 (the returning data is discarded)
  - No issue in this cycle.
  - A pop handshake in the same cycle counts as accepted by decode.
- **hlt=1:**
  - Blocks issue only.
  - An in-flight read still lands and the FIFO still drains.
  - Fetch PC holds.
  - br_ctrl during hlt still redirects.
- instr_vld = (count≠0). instr and pc are driven from the head entry; their values are don't-care when instr_vld=0.

## Timing
- Reset values:
  - fetch PC = imem_addr = fetch_pc = RESET_PC
  - imem_rd_en=0, instr_vld=0, count=0, inflight=0
  - instr=0, pc=0
- Asynchronous reset takes effect immediately, mid-operation included. The queue and in-flight read are lost.
- Startup: cycle 0 = first edge after rst_n rises.
  - Cycle 0: issue RESET_PC.
  - Cycle 1: data on imem_instr.
  - Cycle 2: instr_vld=1, pc=RESET_PC.
- Redirect at cycle r:
  - Cycle r+1: issue new_pc.
  - Cycle r+3: instr_vld with pc=new_pc.
  - There is no bypass. No old-stream entry is visible from r+1 on.
- Steady state with instr_rdy=1 and DEPTH≥3: one instruction per cycle in PC order, with no gaps or duplicates.
- Full queue (count=DEPTH): no issue, instr_vld held, head stable until popped. Issue resumes the cycle after count+inflight drops below DEPTH.
- FIFO pointers wrap modulo DEPTH. DEPTH need not be a power of two.

## Structure
- Package if_pkg holds:
  - the default constants (RESET_PC, PC_INC)
  - the fetch-entry type {pc, instr}
  - the FIFO pointer-width function
- One sub-module, if_fifo: a synchronous FIFO of entries with push, pop, flush (flush dominates push), count, empty and full. if_prefetch holds the PC, the inflight logic and issue control.
- The instruction memory stays outside the block.

## Test plan
- **Streaming:** reset, instr_rdy=1, memory model returns addr^16'hA5A5 → first instr_vld at cycle 2 with pc=0, instr=16'hA5A5. Then pc 1,2,3… on consecutive cycles.
- **Backpressure:** DEPTH=4, instr_rdy=0 → exactly 4 issues (addresses 0–3), then imem_rd_en stays low and pc=0 holds. Release instr_rdy → pcs 0,1,2,3,4… with no gap or duplicate.
- **Redirect:** br_ctrl=1 with new_pc=16'h0040 while inflight=1 and count=2 → instr_vld=0 at r+1 and r+2. At r+3, pc=16'h0040, followed by 0x0041. No old PC ever appears after r.
- **Halt:** hlt=1 for 3 cycles mid-stream → imem_rd_en=0 during those cycles and the in-flight entry still delivered. Resume at the next PC without skip. br_ctrl during hlt redirects correctly.
- **Wrap:** RESET_PC=16'hFFFE → pcs FFFE, FFFF, 0000, 0001.
- **Async reset:** rst_n dropped mid-cycle with a full queue → instr_vld=0 and imem_rd_en=0 before the next edge. After release, the stream restarts at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared constants, fetch-entry type and sizing helper for the prefetching fetch front end.
package if_pkg;

    localparam int          DATA_W_DEF   = 16;
    localparam int          ADDR_W_DEF   = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
    localparam logic [15:0] PC_INC_DEF   = 16'h0001;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] instr;
    } fetch_entry_t;

    // Pointer width for a queue of `depth` entries; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO of fetch entries with flush; flush dominates push and pop.
module if_fifo
    import if_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int PW      = ptr_w(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    input  logic          flush,
    output entry_t        head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register sees the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale
    // contents are never observed and the array maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_prefetch.sv
// Decoupled instruction fetch: owns the fetch PC, issues one read per cycle and queues returns.
module if_prefetch
    import if_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(PC_INC_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hlt,
    input  logic              br_ctrl,
    input  logic [ADDR_W-1:0] new_pc,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc,
    output logic              instr_vld,
    input  logic              instr_rdy,
    output logic [ADDR_W-1:0] fetch_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_pc_q;

    logic              issue;
    logic              push;
    logic              pop;
    logic [CW:0]       occupancy;
    entry_t            push_data;
    entry_t            head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    // Issue looks only at registered occupancy (queued + in flight) so a read is
    // never launched without a guaranteed slot for its return.
    // NOTE: every always_comb output gets a default first so no path leaves a
    // latch behind.
    always_comb begin
        occupancy = {1'b0, fifo_count} + (CW + 1)'(inflight_q);
        issue     = 1'b0;
        push      = 1'b0;
        push_data = '{pc: inflight_pc_q, instr: imem_instr};
        if (rst_n && !br_ctrl && !hlt && !fifo_full && (occupancy < (CW + 1)'(DEPTH))) begin
            issue = 1'b1;
        end
        if (inflight_q && !br_ctrl) begin
            push = 1'b1;
        end
    end

    assign pop        = instr_vld && instr_rdy;
    assign imem_rd_en = issue;
    assign imem_addr  = fetch_pc_q;
    assign fetch_pc   = fetch_pc_q;
    assign instr_vld  = !fifo_empty;
    assign instr      = head.instr;
    assign pc         = head.pc;

    // Redirect wins over everything: new target, and the returning read is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (br_ctrl) begin
            fetch_pc_q <= new_pc;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                fetch_pc_q    <= fetch_pc_q + PC_INC;
                inflight_pc_q <= fetch_pc_q;
            end
        end
    end

    if_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (br_ctrl),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule
